// File: rtl/mmm_dmem_sequencer.sv
// rtl/mmm_dmem_sequencer.sv - matrix-multiply sequencer: reads A/B from data memory, writes C = A x B
module mmm_dmem_sequencer #(
  parameter  int WIDTH        = 32,
  parameter  int SIZE         = 256,
  parameter  int NUM_COL      = 4,
  parameter  int MAX_DIM      = 8,
  localparam int QUARTER_BITS = $clog2(SIZE) - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              dim,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [QUARTER_BITS-1:0] mem1_rd_addr,
  output logic [QUARTER_BITS-1:0] mem2_rd_addr,
  input  logic [WIDTH-1:0]        mem1_rd_data,
  input  logic [WIDTH-1:0]        mem2_rd_data,
  output logic [QUARTER_BITS-1:0] mem3_wr_addr,
  output logic [WIDTH-1:0]        mem3_wr_data,
  output logic [NUM_COL-1:0]      mem3_byte_wren
);

  localparam logic [3:0] MAX_DIM_L = 4'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [3:0]              i_q, i_d;
  logic [3:0]              j_q, j_d;
  logic [3:0]              k_q, k_d;
  // i*N, kept incrementally so no multiplier is needed for addressing
  logic [QUARTER_BITS-1:0] row_base_q, row_base_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [QUARTER_BITS-1:0] rd1_addr_q, rd1_addr_d;
  logic [QUARTER_BITS-1:0] rd2_addr_q, rd2_addr_d;
  logic [QUARTER_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]        wr_data_q, wr_data_d;
  logic [NUM_COL-1:0]      wren_q, wren_d;

  logic [WIDTH-1:0]        prod;
  logic [QUARTER_BITS-1:0] n_ext;
  logic [QUARTER_BITS-1:0] j_ext;
  logic                    dim_ok;
  logic                    last_k;
  logic                    last_j;
  logic                    last_i;

  // Low WIDTH bits of the product are identical for signed and unsigned operands
  always_comb begin
    prod   = mem1_rd_data * mem2_rd_data;
    n_ext  = QUARTER_BITS'(n_q);
    j_ext  = QUARTER_BITS'(j_q);
    dim_ok = (dim != 4'd0) && (dim <= MAX_DIM_L);
    last_k = (k_q == n_q - 4'd1);
    last_j = (j_q == n_q - 4'd1);
    last_i = (i_q == n_q - 4'd1);
  end

  // Next-state and next-output computation; outputs are registered one cycle ahead
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    acc_d      = acc_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd1_addr_d = rd1_addr_q;
    rd2_addr_d = rd2_addr_q;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    wren_d     = '0;

    case (state_q)
      S_IDLE: begin
        rd1_addr_d = '0;
        rd2_addr_d = '0;
        if (start) begin
          if (dim_ok) begin
            n_d        = dim;
            i_d        = 4'd0;
            j_d        = 4'd0;
            k_d        = 4'd0;
            row_base_d = '0;
            acc_d      = '0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        // k==0 means the data on the read ports belongs to the previous element
        if (k_q != 4'd0) begin
          acc_d = acc_q + prod;
        end
        if (last_k) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + 4'd1;
          rd1_addr_d = rd1_addr_q + 1'b1;
          rd2_addr_d = rd2_addr_q + n_ext;
        end
      end

      S_DRAIN: begin
        acc_d     = acc_q + prod;
        wren_d    = '1;
        wr_addr_d = row_base_q + j_ext;
        wr_data_d = acc_q + prod;
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        acc_d = '0;
        k_d   = 4'd0;
        if (last_j) begin
          j_d        = 4'd0;
          i_d        = i_q + 4'd1;
          row_base_d = row_base_q + n_ext;
        end else begin
          j_d = j_q + 4'd1;
        end
        if (last_i && last_j) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          rd1_addr_d = '0;
          rd2_addr_d = '0;
          state_d    = S_DONE;
        end else begin
          // First operands of the next element: A[i'][0] and B[0][j']
          rd1_addr_d = last_j ? (row_base_q + n_ext) : row_base_q;
          rd2_addr_d = last_j ? '0 : (j_ext + 1'b1);
          state_d    = S_ISSUE;
        end
      end

      S_DONE: begin
        rd1_addr_d = '0;
        rd2_addr_d = '0;
        state_d    = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= 4'd0;
      i_q        <= 4'd0;
      j_q        <= 4'd0;
      k_q        <= 4'd0;
      row_base_q <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd1_addr_q <= '0;
      rd2_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wren_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd1_addr_q <= rd1_addr_d;
      rd2_addr_q <= rd2_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wren_q     <= wren_d;
    end
  end

  // Status and write strobes are forced low during reset so no write lands in a reset cycle
  always_comb begin
    busy           = busy_q & ~reset;
    done           = done_q & ~reset;
    err            = err_q;
    mem1_rd_addr   = rd1_addr_q;
    mem2_rd_addr   = rd2_addr_q;
    mem3_wr_addr   = wr_addr_q;
    mem3_wr_data   = wr_data_q;
    mem3_byte_wren = wren_q & {NUM_COL{~reset}};
  end

endmodule
